freq_meter: RTL and testbench

//   Measures a slow, asynchronous square wave such as a divided clock, using the fast system clock CLK.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/freq_meter.sv | 127 ++++++++++++
 tb/tb_freq_meter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter and other async-input blocks.
package freq_meter_pkg;

   // Synchronizer depth used by every async-input front end
   localparam int unsigned SYNC_STAGES = 2;

   // Period measurement FSM states; the spare 2-bit code falls back to ST_ARM
   typedef enum logic [1:0] {
      ST_ARM     = 2'b00,
      ST_RUN     = 2'b01,
      ST_TIMEOUT = 2'b10
   } period_st_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and produces a one-cycle pulse on its rising edge.
module sync_edge_detect
   import freq_meter_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic sig_async,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   // Synchronizer chain followed by a one-stage edge register
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of a slow async signal per gate window and measures its edge-to-edge period.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 26
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_sig,
   output logic [CNT_W-1:0] o_count,
   output logic             o_count_valid,
   output logic             o_count_ovf,
   output logic [CNT_W-1:0] o_period,
   output logic             o_period_valid
);

   localparam int unsigned      G_W     = $clog2(GATE_CYCLES);
   localparam logic [G_W-1:0]   G_LAST  = G_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             rise;
   logic [G_W-1:0]   gate_cnt;
   logic             gate_end;
   logic [CNT_W-1:0] edge_cnt;
   logic             edge_sat;
   logic             ovf_flag;

   period_st_t       state, state_n;
   logic [CNT_W-1:0] per_cnt, per_cnt_n;
   logic [CNT_W-1:0] period_n;
   logic             period_valid_n;

   sync_edge_detect u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .sig_async (i_sig),
      .rise_c    (rise)
   );

   assign gate_end = (gate_cnt == G_LAST);
   assign edge_sat = (edge_cnt == CNT_MAX);

   // Free-running gate window counter
   always_ff @(posedge CLK) begin
      if (RST) gate_cnt <= '0;
      else     gate_cnt <= gate_end ? '0 : gate_cnt + G_W'(1);
   end

   // Edge counter; a rise on the terminal cycle is folded into the ending window
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_cnt      <= '0;
         ovf_flag      <= 1'b0;
         o_count       <= '0;
         o_count_ovf   <= 1'b0;
         o_count_valid <= 1'b0;
      end else begin
         o_count_valid <= gate_end;
         if (gate_end) begin
            o_count     <= (rise && !edge_sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
            o_count_ovf <= ovf_flag | (rise & edge_sat);
            edge_cnt    <= '0;
            ovf_flag    <= 1'b0;
         end else if (rise) begin
            if (edge_sat) ovf_flag <= 1'b1;
            else          edge_cnt <= edge_cnt + CNT_W'(1);
         end
      end
   end

   // Period FSM state and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= ST_ARM;
         per_cnt        <= '0;
         o_period       <= '0;
         o_period_valid <= 1'b0;
      end else begin
         state          <= state_n;
         per_cnt        <= per_cnt_n;
         o_period       <= period_n;
         o_period_valid <= period_valid_n;
      end
   end

   // Period FSM next state: count CLK cycles edge to edge, give up at saturation
   always_comb begin
      state_n        = state;
      per_cnt_n      = per_cnt;
      period_n       = o_period;
      period_valid_n = 1'b0;
      case (state)
         ST_ARM: begin
            per_cnt_n = '0;
            if (rise) begin
               state_n   = ST_RUN;
               per_cnt_n = CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (rise) begin
               period_n       = per_cnt;
               period_valid_n = 1'b1;
               per_cnt_n      = CNT_W'(1);
            end else if (per_cnt == CNT_MAX) begin
               state_n        = ST_TIMEOUT;
               period_n       = CNT_MAX;
               period_valid_n = 1'b1;
            end else begin
               per_cnt_n = per_cnt + CNT_W'(1);
            end
         end
         ST_TIMEOUT: begin
            if (rise) begin
               state_n   = ST_RUN;
               per_cnt_n = CNT_W'(1);
            end
         end
         default: begin
            state_n   = ST_ARM;
            per_cnt_n = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: waveforms per cycle, expected events derived from edge times.
module tb_freq_meter;

   localparam int GC = 100;

   typedef struct packed {
      logic [1:0]  kind;   // 0 = count report, 1 = period report
      logic [31:0] cyc;
      logic [31:0] val;
      logic        ovf;
   } ev_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       i_sig = 1'b0;
   logic [7:0] c8, p8;
   logic       cv8, ov8, pv8;
   logic [4:0] c5, p5;
   logic       cv5, ov5, pv5;

   bit          wave[$];
   ev_t         obs[$];
   ev_t         exp_q[$];
   logic [31:0] rst_snap;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) dut8 (
      .CLK(CLK), .RST(RST), .i_sig(i_sig),
      .o_count(c8), .o_count_valid(cv8), .o_count_ovf(ov8),
      .o_period(p8), .o_period_valid(pv8)
   );

   freq_meter #(.GATE_CYCLES(GC), .CNT_W(5)) dut5 (
      .CLK(CLK), .RST(RST), .i_sig(i_sig),
      .o_count(c5), .o_count_valid(cv5), .o_count_ovf(ov5),
      .o_period(p5), .o_period_valid(pv5)
   );

   // wave[k] is applied just after clock edge k (edge 1 is the first edge out of reset)
   task automatic run_wave(input int rst_cycles, input bit use5, input int n);
      RST   = 1'b1;
      i_sig = 1'b0;
      repeat (rst_cycles) @(posedge CLK);
      #1;
      rst_snap = {c8, cv8, ov8, p8, pv8, c5, cv5, ov5, p5, pv5};
      RST = 1'b0;
      obs.delete();
      i_sig = (wave.size() > 0) ? wave[0] : 1'b0;
      for (int e = 1; e < n; e++) begin
         @(posedge CLK);
         #1;
         if (use5) begin
            if (cv5) obs.push_back(ev_t'{2'd0, 32'(e), 32'(c5), ov5});
            if (pv5) obs.push_back(ev_t'{2'd1, 32'(e), 32'(p5), 1'b0});
         end else begin
            if (cv8) obs.push_back(ev_t'{2'd0, 32'(e), 32'(c8), ov8});
            if (pv8) obs.push_back(ev_t'{2'd1, 32'(e), 32'(p8), 1'b0});
         end
         i_sig = (e < wave.size()) ? wave[e] : 1'b0;
      end
   endtask

   // Reference: a 0->1 step at wave index k is seen by the counters at edge k+3
   function automatic void build_model(input int w, input int last);
      int  mx = (1 << w) - 1;
      int  r[$];
      ev_t cq[$];
      ev_t pq[$];
      int  start = 0;
      bit  running = 1'b0;
      int  i = 0;
      int  j = 0;
      for (int k = 0; k < wave.size(); k++) begin
         bit prev = (k == 0) ? 1'b0 : wave[k-1];
         if (wave[k] && !prev && (k + 3 <= last)) r.push_back(k + 3);
      end
      for (int win = 1; win * GC <= last; win++) begin
         int cnt = 0;
         foreach (r[x]) if (r[x] > (win - 1) * GC && r[x] <= win * GC) cnt++;
         cq.push_back(ev_t'{2'd0, 32'(win * GC), 32'((cnt > mx) ? mx : cnt), (cnt > mx)});
      end
      foreach (r[x]) begin
         if (!running) begin
            running = 1'b1;
         end else if (r[x] - start <= mx) begin
            pq.push_back(ev_t'{2'd1, 32'(r[x]), 32'(r[x] - start), 1'b0});
         end else begin
            pq.push_back(ev_t'{2'd1, 32'(start + mx), 32'(mx), 1'b0});
         end
         start = r[x];
      end
      if (running && (start + mx <= last))
         pq.push_back(ev_t'{2'd1, 32'(start + mx), 32'(mx), 1'b0});
      exp_q.delete();
      while (i < cq.size() || j < pq.size()) begin
         if (j >= pq.size() || (i < cq.size() && cq[i].cyc <= pq[j].cyc)) begin
            exp_q.push_back(cq[i]);
            i++;
         end else begin
            exp_q.push_back(pq[j]);
            j++;
         end
      end
   endfunction

   function automatic void make_square(input int half, input int n);
      wave.delete();
      for (int k = 0; k < n; k++) wave.push_back(((k / half) % 2) == 1);
   endfunction

   task automatic test_reset();
      RST   = 1'b1;
      i_sig = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({c8, cv8, ov8, p8, pv8, c5, cv5, ov5, p5, pv5} !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {c8, cv8, ov8, p8, pv8, c5, cv5, ov5, p5, pv5});
      end
   endtask

   task automatic test_square();
      make_square(5, 350);
      run_wave(2, 1'b0, 350);
      build_model(8, 349);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL square_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL square_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
      foreach (obs[i]) begin
         if (obs[i].kind == 2'd0) begin
            checks++;
            if (obs[i].val !== 32'd10 || obs[i].ovf !== 1'b0) begin
               errors++;
               $display("FAIL square_count got %0d ovf %0d want 10 ovf 0", obs[i].val, obs[i].ovf);
            end
         end
      end
   endtask

   task automatic test_idle();
      wave.delete();
      for (int k = 0; k < 302; k++) wave.push_back(1'b0);
      run_wave(2, 1'b0, 302);
      build_model(8, 301);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL idle_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL idle_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
   endtask

   task automatic test_saturate();
      wave.delete();
      for (int k = 0; k < 320; k++) wave.push_back((k < 200) && (k % 2 == 1));
      run_wave(2, 1'b1, 320);
      build_model(5, 319);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL sat_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL sat_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
   endtask

   task automatic test_timeout();
      wave.delete();
      for (int k = 0; k < 400; k++)
         wave.push_back((k >= 10 && k < 13) || (k >= 310 && k < 313) || (k >= 330 && k < 333));
      run_wave(2, 1'b0, 400);
      build_model(8, 399);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL timeout_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL timeout_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
   endtask

   task automatic test_terminal();
      wave.delete();
      for (int k = 0; k < 320; k++)
         wave.push_back(k == 20 || k == 50 || k == 97 || k == 99 || k == 197 || k == 297);
      run_wave(2, 1'b0, 320);
      build_model(8, 319);
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL term_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL term_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         bit lvl  = 1'b0;
         int maxr = (it % 2 == 0) ? 8 : 60;
         wave.delete();
         while (wave.size() < 500) begin
            int len = $urandom_range(1, maxr);
            for (int j = 0; j < len; j++) wave.push_back(lvl);
            lvl = ~lvl;
         end
         run_wave(2, it[0], 500);
         build_model(it[0] ? 5 : 8, 499);
         checks++;
         if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_events got %0d want %0d", it, obs.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand%0d_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", it, i,
                        obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                        exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      make_square(7, 150);
      run_wave(2, 1'b0, 150);
      make_square(9, 260);
      run_wave(1, 1'b0, 260);
      build_model(8, 259);
      checks++;
      if (rst_snap !== 32'd0) begin
         errors++;
         $display("FAIL midreset_outputs got %h want 0", rst_snap);
      end
      checks++;
      if (obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midreset_events got %0d want %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         checks++;
         if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_ev[%0d] got k%0d c%0d v%0d o%0d want k%0d c%0d v%0d o%0d", i,
                     obs[i].kind, obs[i].cyc, obs[i].val, obs[i].ovf,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_square();
      test_idle();
      test_saturate();
      test_timeout();
      test_terminal();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
